// File: rtl/ternary_imem_loader_pkg.sv
// Shared trit encoding, loader FSM states and trit validity helper for the
// instruction-memory loader.
package ternary_imem_loader_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO    = 2'b00;
    localparam trit_t T_POS_ONE = 2'b01;
    localparam trit_t T_NEG_ONE = 2'b10;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        LOAD    = 3'd1,
        DRAIN   = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4
    } loader_state_e;

    function automatic logic is_valid_trit(input trit_t t);
        return (t == T_ZERO) || (t == T_POS_ONE) || (t == T_NEG_ONE);
    endfunction

endpackage

// File: rtl/ternary_imem_loader_if.sv
// Program-load stream: a beat transfers on a clock edge where prog_we && prog_ready;
// prog_ready never depends combinationally on prog_we.
interface ternary_imem_loader_if;
    import ternary_imem_loader_pkg::*;

    logic        prog_mode;
    logic [7:0]  prog_addr;
    trit_t [8:0] prog_data;
    logic        prog_we;
    logic        prog_ready;

    modport master (output prog_mode, prog_addr, prog_data, prog_we, input prog_ready);
    modport slave  (input prog_mode, prog_addr, prog_data, prog_we, output prog_ready);

endinterface

// File: rtl/ternary_imem_loader_bin2bt.sv
// Combinational unsigned binary to balanced-ternary converter; trit[0] is the
// least significant digit and unused high trits come out as T_ZERO.
module ternary_bin2bt
    import ternary_imem_loader_pkg::*;
#(
    parameter int BIN_W = 8,
    parameter int TRITS = 8
) (
    input  logic [BIN_W-1:0]  bin,
    output trit_t [TRITS-1:0] bt
);

    localparam logic [BIN_W:0] THREE = (BIN_W+1)'(3);
    localparam logic [BIN_W:0] ONE   = (BIN_W+1)'(1);

    always_comb begin
        logic [BIN_W:0] v;
        logic [BIN_W:0] q;
        logic [BIN_W:0] r;
        bt = '0;
        v  = {1'b0, bin};
        for (int i = 0; i < TRITS; i++) begin
            q = v / THREE;
            r = v % THREE;
            case (r[1:0])
                2'd1:    begin bt[i] = T_POS_ONE; v = q;       end
                // Digit 2 is written as -1 with a carry into the next place.
                2'd2:    begin bt[i] = T_NEG_ONE; v = q + ONE; end
                default: begin bt[i] = T_ZERO;    v = q;       end
            endcase
        end
    end

endmodule

// File: rtl/ternary_imem_loader.sv
// Sequences an external program load into the instruction memory write port and
// holds the CPU core in reset until the load completes plus a settle interval.
module ternary_imem_loader
    import ternary_imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH     = 243,
    parameter int RELEASE_CYCLES = 4,
    parameter int ADDR_TRITS     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    ternary_imem_loader_if.slave    prog,
    output logic                    imem_wr_en,
    output trit_t [ADDR_TRITS-1:0]  imem_wr_addr,
    output trit_t [8:0]             imem_wr_data,
    output logic                    cpu_rst_n,
    output logic                    load_busy,
    output logic [7:0]              load_count,
    output logic                    load_error,
    output loader_state_e           state
);

    localparam logic [8:0] DEPTH   = 9'(IMEM_DEPTH);
    localparam logic [3:0] REL_INI = 4'(RELEASE_CYCLES);

    loader_state_e          state_next;
    logic [3:0]             rel_cnt, rel_next;
    logic                   clear_session;
    logic                   accept, in_range, bad_data;
    trit_t [ADDR_TRITS-1:0] addr_bt;
    trit_t [8:0]            clean_data;

    ternary_bin2bt #(.BIN_W(8), .TRITS(ADDR_TRITS)) u_bin2bt (
        .bin (prog.prog_addr),
        .bt  (addr_bt)
    );

    assign prog.prog_ready = (state == LOAD);
    assign cpu_rst_n       = (state == RUN);
    assign load_busy       = (state != RUN);

    assign accept   = (state == LOAD) && prog.prog_we;
    assign in_range = ({1'b0, prog.prog_addr} < DEPTH);

    always_comb begin
        bad_data   = 1'b0;
        clean_data = prog.prog_data;
        for (int i = 0; i < 9; i++) begin
            if (!is_valid_trit(prog.prog_data[i])) begin
                clean_data[i] = T_ZERO;
                bad_data      = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        rel_next      = rel_cnt;
        clear_session = 1'b0;
        case (state)
            HOLD: begin
                if (prog.prog_mode) begin
                    state_next    = LOAD;
                    clear_session = 1'b1;
                end else begin
                    // Release the core even when no program is ever loaded.
                    state_next = RELEASE;
                    rel_next   = REL_INI;
                end
            end
            LOAD: begin
                if (!prog.prog_mode) state_next = DRAIN;
            end
            DRAIN: begin
                state_next = RELEASE;
                rel_next   = REL_INI;
            end
            RELEASE: begin
                if (prog.prog_mode) begin
                    state_next = LOAD;
                end else if (rel_cnt <= 4'd1) begin
                    state_next = RUN;
                    rel_next   = 4'd0;
                end else begin
                    rel_next = rel_cnt - 4'd1;
                end
            end
            RUN: begin
                if (prog.prog_mode) begin
                    state_next    = LOAD;
                    clear_session = 1'b1;
                end
            end
            default: state_next = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HOLD;
            rel_cnt      <= 4'd0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= {ADDR_TRITS{T_ZERO}};
            imem_wr_data <= {9{T_ZERO}};
            load_count   <= 8'd0;
            load_error   <= 1'b0;
        end else begin
            state      <= state_next;
            rel_cnt    <= rel_next;
            imem_wr_en <= accept && in_range;
            if (accept && in_range) begin
                imem_wr_addr <= addr_bt;
                imem_wr_data <= clean_data;
            end
            if (clear_session) begin
                load_count <= 8'd0;
                load_error <= 1'b0;
            end else if (accept) begin
                if (!in_range) begin
                    load_error <= 1'b1;
                end else begin
                    if (load_count != 8'hFF) load_count <= load_count + 8'd1;
                    if (bad_data) load_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ternary_imem_loader.sv
// Directed bench for the instruction-memory loader with hand-computed expectations.
module tb_ternary_imem_loader;
    import ternary_imem_loader_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                imem_wr_en;
    trit_t [7:0]         imem_wr_addr;
    trit_t [8:0]         imem_wr_data;
    logic                cpu_rst_n;
    logic                load_busy;
    logic [7:0]          load_count;
    logic                load_error;
    loader_state_e       state;

    int total = 0;
    int bad   = 0;
    int low_cycles;
    int pulses;

    localparam logic [31:0] DATA_ALL_P  = 32'h15555;
    localparam logic [31:0] DATA_T4_ZRO = 32'h15455;

    ternary_imem_loader_if pif();

    ternary_imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .prog         (pif.slave),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_rst_n    (cpu_rst_n),
        .load_busy    (load_busy),
        .load_count   (load_count),
        .load_error   (load_error),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all_p();
        for (int i = 0; i < 9; i++) pif.prog_data[i] = T_POS_ONE;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(HOLD));
        chk({tag, "_wr_en"}, 32'(imem_wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(imem_wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(imem_wr_data), 32'd0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_busy"}, 32'(load_busy), 32'd1);
        chk({tag, "_count"}, 32'(load_count), 32'd0);
        chk({tag, "_error"}, 32'(load_error), 32'd0);
        chk({tag, "_ready"}, 32'(pif.prog_ready), 32'd0);
    endtask

    // Ends a session and waits through DRAIN plus the release interval.
    task automatic finish_session(input string tag);
        pif.prog_we   = 1'b0;
        pif.prog_mode = 1'b0;
        repeat (6) tick();
        chk({tag, "_run"}, 32'(cpu_rst_n), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        pif.prog_mode = 1'b0;
        pif.prog_we   = 1'b0;
        pif.prog_addr = 8'd0;
        pif.prog_data = '0;
        tick();
        check_reset_values("reset");

        // No program: core is released after HOLD plus four RELEASE cycles.
        rst = 1'b0;
        pif.prog_we   = 1'b1;
        pif.prog_addr = 8'd3;
        low_cycles = 1;
        pulses     = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_wr_en) pulses++;
            if (cpu_rst_n) break;
            low_cycles++;
        end
        pif.prog_we = 1'b0;
        chk("noprog_low_cycles", 32'(low_cycles), 32'd5);
        chk("noprog_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("noprog_busy", 32'(load_busy), 32'd0);
        chk("noprog_state", 32'(state), 32'(RUN));
        chk("noprog_wr_pulses", 32'(pulses), 32'd0);

        // Session with beats at 0, 5, 242.
        pif.prog_mode = 1'b1;
        tick();
        chk("s1_state_load", 32'(state), 32'(LOAD));
        chk("s1_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("s1_ready", 32'(pif.prog_ready), 32'd1);
        set_all_p();
        pif.prog_we   = 1'b1;
        pif.prog_addr = 8'd0;
        tick();
        chk("s1_a0_wr_en", 32'(imem_wr_en), 32'd1);
        chk("s1_a0_addr", 32'(imem_wr_addr), 32'h0000);
        chk("s1_a0_data", 32'(imem_wr_data), DATA_ALL_P);
        pif.prog_addr = 8'd5;
        tick();
        chk("s1_a5_wr_en", 32'(imem_wr_en), 32'd1);
        chk("s1_a5_addr", 32'(imem_wr_addr), 32'h001A);
        pif.prog_addr = 8'd242;
        tick();
        chk("s1_a242_wr_en", 32'(imem_wr_en), 32'd1);
        chk("s1_a242_addr", 32'(imem_wr_addr), 32'h0402);
        pif.prog_we = 1'b0;
        tick();
        chk("s1_idle_wr_en", 32'(imem_wr_en), 32'd0);
        chk("s1_count", 32'(load_count), 32'd3);
        chk("s1_error", 32'(load_error), 32'd0);
        pif.prog_mode = 1'b0;
        tick();
        chk("s1_drain", 32'(state), 32'(DRAIN));
        chk("s1_drain_ready", 32'(pif.prog_ready), 32'd0);
        repeat (4) tick();
        chk("s1_rel_last", 32'(state), 32'(RELEASE));
        chk("s1_rel_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        tick();
        chk("s1_run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("s1_run_busy", 32'(load_busy), 32'd0);

        // In-range beat then an out-of-range beat.
        pif.prog_mode = 1'b1;
        tick();
        pif.prog_we   = 1'b1;
        pif.prog_addr = 8'd10;
        tick();
        chk("s2_a10_addr", 32'(imem_wr_addr), 32'h0011);
        chk("s2_a10_count", 32'(load_count), 32'd1);
        pif.prog_addr = 8'd243;
        tick();
        chk("s2_a243_wr_en", 32'(imem_wr_en), 32'd0);
        chk("s2_a243_error", 32'(load_error), 32'd1);
        chk("s2_a243_count", 32'(load_count), 32'd1);
        finish_session("s2");

        // New session clears the error; then an invalid trit4 is sanitised.
        pif.prog_mode = 1'b1;
        tick();
        chk("s3_error_cleared", 32'(load_error), 32'd0);
        chk("s3_count_cleared", 32'(load_count), 32'd0);
        pif.prog_we   = 1'b1;
        pif.prog_addr = 8'd1;
        pif.prog_data[4] = 2'b11;
        tick();
        chk("s3_bad_wr_en", 32'(imem_wr_en), 32'd1);
        chk("s3_bad_addr", 32'(imem_wr_addr), 32'h0001);
        chk("s3_bad_data", 32'(imem_wr_data), DATA_T4_ZRO);
        chk("s3_bad_error", 32'(load_error), 32'd1);
        chk("s3_bad_count", 32'(load_count), 32'd1);
        set_all_p();
        finish_session("s3");

        // Final beat coincides with prog_mode falling.
        pif.prog_mode = 1'b1;
        tick();
        pif.prog_we   = 1'b1;
        pif.prog_addr = 8'd7;
        pif.prog_mode = 1'b0;
        tick();
        pif.prog_we = 1'b0;
        chk("s4_drain_state", 32'(state), 32'(DRAIN));
        chk("s4_drain_wr_en", 32'(imem_wr_en), 32'd1);
        chk("s4_drain_addr", 32'(imem_wr_addr), 32'h0019);
        chk("s4_count", 32'(load_count), 32'd1);
        repeat (5) tick();
        chk("s4_run", 32'(state), 32'(RUN));
        pif.prog_mode = 1'b1;
        tick();
        chk("s4_reenter_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("s4_reenter_state", 32'(state), 32'(LOAD));

        // Reset mid-LOAD with a write pending and another beat offered.
        pif.prog_we   = 1'b1;
        pif.prog_addr = 8'd3;
        tick();
        chk("s5_pending_wr_en", 32'(imem_wr_en), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_values("s5_rst");
        rst = 1'b0;
        pif.prog_we   = 1'b0;
        pif.prog_mode = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
